// File: rtl/bp_pkg.sv
// ============================================================================
// Package : bp_pkg
// Shared types for the branch predictor and its resolve queue.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bp_pkg;

  localparam int BP_PC_W = 10;

  typedef enum logic [1:0] {
    BRQ_FREE     = 2'd0,
    BRQ_PENDING  = 2'd1,
    BRQ_RESOLVED = 2'd2
  } brq_state_t;

  typedef struct packed {
    brq_state_t         state;
    logic [BP_PC_W-1:0] pc;
    logic               local_pred;
    logic               global_pred;
    logic               choice;
  } brq_entry_t;

endpackage

`default_nettype wire

// File: rtl/brq_age_cmp.sv
// ============================================================================
// Module : brq_age_cmp
// Flags a tag that is occupied and strictly younger than a reference tag.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module brq_age_cmp #(
  parameter int TAG_W = 3
) (
  input  logic [TAG_W:0]   head,
  input  logic [TAG_W:0]   tail,
  input  logic [TAG_W-1:0] ref_tag,
  input  logic [TAG_W-1:0] tag,
  output logic             younger
);

  logic [TAG_W-1:0] w_tag_off;
  logic [TAG_W-1:0] w_ref_off;
  logic [TAG_W:0]   w_count;

  // Ages are distances from head; modulo arithmetic absorbs the wrap.
  assign w_tag_off = tag - head[TAG_W-1:0];
  assign w_ref_off = ref_tag - head[TAG_W-1:0];
  assign w_count   = tail - head;
  assign younger   = ({1'b0, w_tag_off} < w_count) && (w_tag_off > w_ref_off);

endmodule

`default_nettype wire

// File: rtl/branch_resolve_queue.sv
// ============================================================================
// Module : branch_resolve_queue
// In-order branch resolution queue: mispredict flush and predictor training.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int PC_W  = BP_PC_W,
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [PC_W-1:0]  alloc_pc,
  input  logic             alloc_local_pred,
  input  logic             alloc_global_pred,
  input  logic             alloc_choice,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  output logic             mispredict,
  output logic [TAG_W-1:0] mispredict_tag,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             upd_local_ok,
  output logic             upd_global_ok,
  output logic [TAG_W:0]   count
);

  brq_entry_t       r_entries [DEPTH];
  logic [DEPTH-1:0] r_taken;
  logic [TAG_W:0]   r_head;
  logic [TAG_W:0]   r_tail;

  logic             r_mispredict;
  logic [TAG_W-1:0] r_mispredict_tag;
  logic             r_upd_valid;
  logic [PC_W-1:0]  r_upd_pc;
  logic             r_upd_taken;
  logic             r_upd_local_ok;
  logic             r_upd_global_ok;

  logic [TAG_W-1:0] w_head_idx;
  logic [TAG_W-1:0] w_tail_idx;
  logic [TAG_W:0]   w_count;
  logic             w_full;
  logic             w_alloc;
  logic             w_res_hit;
  logic             w_final_pred;
  logic             w_mispredict;
  logic             w_retire;
  logic [TAG_W:0]   w_res_abs;
  logic [TAG_W:0]   w_new_tail;
  logic [DEPTH-1:0] w_younger;

  assign w_head_idx   = r_head[TAG_W-1:0];
  assign w_tail_idx   = r_tail[TAG_W-1:0];
  assign w_count      = r_tail - r_head;
  assign w_full       = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);
  assign w_alloc      = alloc_valid && !w_full;
  assign w_res_hit    = res_valid && (r_entries[res_tag].state == BRQ_PENDING);
  assign w_final_pred = r_entries[res_tag].choice ? r_entries[res_tag].global_pred
                                                  : r_entries[res_tag].local_pred;
  assign w_mispredict = w_res_hit && (w_final_pred != res_taken);
  assign w_retire     = (r_entries[w_head_idx].state == BRQ_RESOLVED);

  // A tag below the head index lives on the next lap, so its wrap bit is flipped.
  assign w_res_abs  = (res_tag >= w_head_idx) ? {r_head[TAG_W], res_tag}
                                              : {~r_head[TAG_W], res_tag};
  assign w_new_tail = w_res_abs + 1'b1;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_age
      brq_age_cmp #(
        .TAG_W(TAG_W)
      ) u_age_cmp (
        .head   (r_head),
        .tail   (r_tail),
        .ref_tag(res_tag),
        .tag    (TAG_W'(i)),
        .younger(w_younger[i])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].state       <= BRQ_FREE;
        r_entries[i].pc          <= '0;
        r_entries[i].local_pred  <= 1'b0;
        r_entries[i].global_pred <= 1'b0;
        r_entries[i].choice      <= 1'b0;
      end
      r_taken <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_retire) begin
        r_entries[w_head_idx].state <= BRQ_FREE;
        r_head                      <= r_head + 1'b1;
      end
      if (w_res_hit) begin
        r_entries[res_tag].state <= BRQ_RESOLVED;
        r_taken[res_tag]         <= res_taken;
      end
      // A same-edge alloc is on the wrong path once a mispredict fires.
      if (w_mispredict) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_younger[i]) begin
            r_entries[i].state <= BRQ_FREE;
          end
        end
        r_tail <= w_new_tail;
      end else if (w_alloc) begin
        r_entries[w_tail_idx].state       <= BRQ_PENDING;
        r_entries[w_tail_idx].pc          <= alloc_pc;
        r_entries[w_tail_idx].local_pred  <= alloc_local_pred;
        r_entries[w_tail_idx].global_pred <= alloc_global_pred;
        r_entries[w_tail_idx].choice      <= alloc_choice;
        r_tail                            <= r_tail + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mispredict     <= 1'b0;
      r_mispredict_tag <= '0;
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_taken      <= 1'b0;
      r_upd_local_ok   <= 1'b0;
      r_upd_global_ok  <= 1'b0;
    end else begin
      r_mispredict <= w_mispredict;
      r_upd_valid  <= w_retire;
      if (w_mispredict) begin
        r_mispredict_tag <= res_tag;
      end
      if (w_retire) begin
        r_upd_pc        <= r_entries[w_head_idx].pc;
        r_upd_taken     <= r_taken[w_head_idx];
        r_upd_local_ok  <= (r_entries[w_head_idx].local_pred == r_taken[w_head_idx]);
        r_upd_global_ok <= (r_entries[w_head_idx].global_pred == r_taken[w_head_idx]);
      end
    end
  end

  assign alloc_ready    = !w_full;
  assign alloc_tag      = w_tail_idx;
  assign count          = w_count;
  assign mispredict     = r_mispredict;
  assign mispredict_tag = r_mispredict_tag;
  assign upd_valid      = r_upd_valid;
  assign upd_pc         = r_upd_pc;
  assign upd_taken      = r_upd_taken;
  assign upd_local_ok   = r_upd_local_ok;
  assign upd_global_ok  = r_upd_global_ok;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// ============================================================================
// Module : tb_branch_resolve_queue
// Directed self-checking bench for branch_resolve_queue.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [9:0] alloc_pc;
  logic       alloc_local_pred;
  logic       alloc_global_pred;
  logic       alloc_choice;
  logic [2:0] alloc_tag;
  logic       res_valid;
  logic [2:0] res_tag;
  logic       res_taken;
  logic       mispredict;
  logic [2:0] mispredict_tag;
  logic       upd_valid;
  logic [9:0] upd_pc;
  logic       upd_taken;
  logic       upd_local_ok;
  logic       upd_global_ok;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  branch_resolve_queue dut (
    .clock            (clock),
    .reset            (reset),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_pc         (alloc_pc),
    .alloc_local_pred (alloc_local_pred),
    .alloc_global_pred(alloc_global_pred),
    .alloc_choice     (alloc_choice),
    .alloc_tag        (alloc_tag),
    .res_valid        (res_valid),
    .res_tag          (res_tag),
    .res_taken        (res_taken),
    .mispredict       (mispredict),
    .mispredict_tag   (mispredict_tag),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_local_ok     (upd_local_ok),
    .upd_global_ok    (upd_global_ok),
    .count            (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [9:0] pc, input logic l, input logic g,
                           input logic c);
    alloc_valid       = v;
    alloc_pc          = pc;
    alloc_local_pred  = l;
    alloc_global_pred = g;
    alloc_choice      = c;
  endtask

  task automatic set_res(input logic v, input logic [2:0] tag, input logic taken);
    res_valid = v;
    res_tag   = tag;
    res_taken = taken;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_alloc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    set_res(1'b0, 3'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    tick();
    check("rst_ready", 32'(alloc_ready), 32'd1);
    check("rst_tag", 32'(alloc_tag), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_upd", 32'(upd_valid), 32'd0);
    check("rst_mp", 32'(mispredict), 32'd0);

    // Single branch, local prediction used and correct.
    set_alloc(1'b1, 10'h12, 1'b1, 1'b0, 1'b0);
    tick();
    set_alloc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    check("t1_count", 32'(count), 32'd1);
    check("t1_tag", 32'(alloc_tag), 32'd1);
    set_res(1'b1, 3'd0, 1'b1);
    tick();
    set_res(1'b0, 3'd0, 1'b0);
    check("t1_no_mp", 32'(mispredict), 32'd0);
    check("t1_no_upd_yet", 32'(upd_valid), 32'd0);
    tick();
    check("t1_upd", 32'(upd_valid), 32'd1);
    check("t1_pc", 32'(upd_pc), 32'h12);
    check("t1_taken", 32'(upd_taken), 32'd1);
    check("t1_lok", 32'(upd_local_ok), 32'd1);
    check("t1_gok", 32'(upd_global_ok), 32'd0);
    check("t1_count0", 32'(count), 32'd0);
    tick();
    check("t1_upd_pulse", 32'(upd_valid), 32'd0);

    // Fill to capacity, overflow attempt, retire, then mispredict across the wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(1'b1, 10'(32'h20 + i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    check("t2_full_count", 32'(count), 32'd8);
    check("t2_not_ready", 32'(alloc_ready), 32'd0);
    set_alloc(1'b1, 10'h3ff, 1'b0, 1'b0, 1'b0);
    tick();
    check("t2_ninth_ignored", 32'(count), 32'd8);
    set_alloc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    set_res(1'b1, 3'd0, 1'b1);
    tick();
    set_res(1'b0, 3'd0, 1'b0);
    check("t2_still_full", 32'(alloc_ready), 32'd0);
    tick();
    check("t2_upd", 32'(upd_valid), 32'd1);
    check("t2_pc", 32'(upd_pc), 32'h20);
    check("t2_count7", 32'(count), 32'd7);
    check("t2_ready", 32'(alloc_ready), 32'd1);
    check("t2_tag_wrap", 32'(alloc_tag), 32'd0);
    set_res(1'b1, 3'd3, 1'b0);
    tick();
    set_res(1'b0, 3'd0, 1'b0);
    check("t2_mp", 32'(mispredict), 32'd1);
    check("t2_mp_tag", 32'(mispredict_tag), 32'd3);
    check("t2_mp_count", 32'(count), 32'd3);
    check("t2_mp_alloc_tag", 32'(alloc_tag), 32'd4);

    // Five allocs, mispredict tag1 while a sixth alloc is offered.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 10'(32'h40 + i), 1'b1, 1'b1, 1'b1);
      tick();
    end
    set_res(1'b1, 3'd1, 1'b0);
    tick();
    set_alloc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    set_res(1'b0, 3'd0, 1'b0);
    check("t3_mp", 32'(mispredict), 32'd1);
    check("t3_mp_tag", 32'(mispredict_tag), 32'd1);
    check("t3_count", 32'(count), 32'd2);
    check("t3_next_tag", 32'(alloc_tag), 32'd2);
    tick();
    check("t3_mp_pulse", 32'(mispredict), 32'd0);
    check("t3_no_upd", 32'(upd_valid), 32'd0);

    // Out-of-order resolve 2,0,1 with an alloc alongside the first retire.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 10'(32'h50 + i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_alloc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    set_res(1'b1, 3'd2, 1'b1);
    tick();
    set_res(1'b1, 3'd0, 1'b1);
    tick();
    check("t4_no_upd_yet", 32'(upd_valid), 32'd0);
    set_res(1'b1, 3'd1, 1'b1);
    set_alloc(1'b1, 10'h53, 1'b1, 1'b0, 1'b0);
    tick();
    set_res(1'b0, 3'd0, 1'b0);
    set_alloc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    check("t4_upd0", 32'(upd_valid), 32'd1);
    check("t4_pc0", 32'(upd_pc), 32'h50);
    check("t4_count_same", 32'(count), 32'd3);
    tick();
    check("t4_upd1", 32'(upd_valid), 32'd1);
    check("t4_pc1", 32'(upd_pc), 32'h51);
    tick();
    check("t4_upd2", 32'(upd_valid), 32'd1);
    check("t4_pc2", 32'(upd_pc), 32'h52);
    check("t4_count1", 32'(count), 32'd1);
    tick();
    check("t4_upd_done", 32'(upd_valid), 32'd0);

    // Resolve of a FREE tag, then a duplicate resolve of tag3.
    set_res(1'b1, 3'd5, 1'b0);
    tick();
    set_res(1'b0, 3'd0, 1'b0);
    check("t5_free_no_mp", 32'(mispredict), 32'd0);
    check("t5_free_count", 32'(count), 32'd1);
    tick();
    check("t5_free_no_upd", 32'(upd_valid), 32'd0);
    set_res(1'b1, 3'd3, 1'b1);
    tick();
    set_res(1'b1, 3'd3, 1'b0);
    tick();
    set_res(1'b0, 3'd0, 1'b0);
    check("t5_dup_no_mp", 32'(mispredict), 32'd0);
    check("t5_dup_upd", 32'(upd_valid), 32'd1);
    check("t5_dup_taken", 32'(upd_taken), 32'd1);
    check("t5_dup_count", 32'(count), 32'd0);

    // Reset with four entries pending and a resolve on the reset edge.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(1'b1, 10'(32'h60 + i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    set_alloc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    check("t6_count4", 32'(count), 32'd4);
    reset = 1'b1;
    set_res(1'b1, 3'd0, 1'b0);
    tick();
    reset = 1'b0;
    set_res(1'b0, 3'd0, 1'b0);
    check("t6_count0", 32'(count), 32'd0);
    check("t6_tag0", 32'(alloc_tag), 32'd0);
    check("t6_ready", 32'(alloc_ready), 32'd1);
    tick();
    check("t6_no_upd", 32'(upd_valid), 32'd0);
    check("t6_no_mp", 32'(mispredict), 32'd0);
    tick();
    check("t6_no_upd2", 32'(upd_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
